// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared pipeline constants for the ID/EX hazard controller.
// Holds the FSM encoding, the zero register, control-set encodings and decoder opcodes.
package id_ex_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Opcodes the decoder uses to derive id_uses_rt / id_is_branch
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};

  function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic op_is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// ID/EX hazard bundle: decode/execute status in, pipeline enables and counters out.
interface id_ex_hazard_ctrl_if #(parameter int unsigned CNT_W = 16);
  import id_ex_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_dest;
  logic             ex_pcsrc;
  logic             ex_jump;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch,
    output ex_memread, ex_regwrite, ex_dest, ex_pcsrc, ex_jump,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch,
    input  ex_memread, ex_regwrite, ex_dest, ex_pcsrc, ex_jump,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX write-side controller: load-use / branch-operand stalls, EX-resolved flushes,
// and saturating stall/flush counters. Control outputs are Mealy (same-cycle).
module id_ex_hazard_ctrl
  import id_ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  id_ex_hazard_ctrl_if.slave hz
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  ctrl_t      ctrl_c;
  logic       stall_inc_c;
  logic       flush_inc_c;

  logic match_rs_c;
  logic match_rt_c;
  logic dep_c;
  logic flush_req_c;
  logic lb_haz_c;
  logic lu_haz_c;
  logic ab_haz_c;

  // $0 is hardwired, so a write to it never creates a dependency
  always_comb begin
    match_rs_c  = (hz.ex_dest != REG_ZERO) && (hz.ex_dest == hz.id_rs);
    match_rt_c  = hz.id_uses_rt && (hz.ex_dest != REG_ZERO) && (hz.ex_dest == hz.id_rt);
    dep_c       = match_rs_c || match_rt_c;
    flush_req_c = hz.ex_pcsrc || hz.ex_jump;
    lb_haz_c    = hz.ex_memread && hz.id_is_branch && dep_c;
    lu_haz_c    = hz.ex_memread && !hz.id_is_branch && dep_c;
    ab_haz_c    = hz.ex_regwrite && !hz.ex_memread && hz.id_is_branch && dep_c;
  end

  always_comb begin
    state_d     = ST_RUN;
    ctrl_c      = CTRL_NORMAL;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;
    if (reset) begin
      ctrl_c = CTRL_RESET;
    end else if (flush_req_c) begin
      ctrl_c      = CTRL_FLUSH;
      flush_inc_c = 1'b1;
    end else if (state_q == ST_HOLD) begin
      // Second load->branch stall while the load sits in MEM
      ctrl_c      = CTRL_STALL;
      stall_inc_c = 1'b1;
    end else if (lb_haz_c) begin
      ctrl_c      = CTRL_STALL;
      stall_inc_c = 1'b1;
      state_d     = ST_HOLD;
    end else if (lu_haz_c || ab_haz_c) begin
      ctrl_c      = CTRL_STALL;
      stall_inc_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.pc_write    = ctrl_c.pc_write;
  assign hz.ifid_write  = ctrl_c.ifid_write;
  assign hz.ifid_flush  = ctrl_c.ifid_flush;
  assign hz.idex_bubble = ctrl_c.idex_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_c),
    .count (hz.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_c),
    .count (hz.flush_events)
  );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. A CNT_W=4 twin exercises saturation.
module tb_id_ex_hazard_ctrl;

  logic clk;
  logic reset;

  id_ex_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
  id_ex_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  id_ex_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .hz(bus16.slave));
  id_ex_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .hz(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] F = 4'b1111;
  localparam logic [3:0] R = 4'b0011;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    bit          chk_cnt;
    logic [15:0] st;
    logic [15:0] fl;
    logic [3:0]  st4;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  logic [15:0] m_st  = '0;
  logic [15:0] m_fl  = '0;
  logic [3:0]  m_st4 = '0;

  task automatic chk(input string nm, input string what, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s/%s: got %h want %h @%0t", nm, what, act, req, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic br,
                       input logic mr, input logic rw, input logic [4:0] dst,
                       input logic pcs, input logic jmp);
    bus16.id_rs = rs;  bus16.id_rt = rt;  bus16.id_uses_rt = urt; bus16.id_is_branch = br;
    bus16.ex_memread = mr; bus16.ex_regwrite = rw; bus16.ex_dest = dst;
    bus16.ex_pcsrc = pcs; bus16.ex_jump = jmp;
    bus4.id_rs = rs;   bus4.id_rt = rt;   bus4.id_uses_rt = urt;  bus4.id_is_branch = br;
    bus4.ex_memread = mr;  bus4.ex_regwrite = rw;  bus4.ex_dest = dst;
    bus4.ex_pcsrc = pcs;  bus4.ex_jump = jmp;
  endtask

  // One cycle of stimulus; expected control class is hand-chosen, counters tracked from it
  task automatic vec(input string nm, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic br, input logic mr, input logic rw, input logic [4:0] dst,
                     input logic pcs, input logic jmp, input logic rstv, input logic [3:0] ctl,
                     input bit chkc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rstv;
    drive(rs, rt, urt, br, mr, rw, dst, pcs, jmp);
    e.name = nm; e.ctl = ctl; e.chk_cnt = chkc;
    e.st = m_st; e.fl = m_fl; e.st4 = m_st4;
    sbq.push_back(e);
    if (rstv) begin
      m_st = '0; m_fl = '0; m_st4 = '0;
    end else if (ctl == S) begin
      m_st = m_st + 16'd1;
      if (m_st4 != 4'hf) m_st4 = m_st4 + 4'd1;
    end else if (ctl == F) begin
      m_fl = m_fl + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.name, "ctl16", {12'd0, bus16.pc_write, bus16.ifid_write, bus16.ifid_flush, bus16.idex_bubble},
          {12'd0, e.ctl});
      chk(e.name, "ctl4", {12'd0, bus4.pc_write, bus4.ifid_write, bus4.ifid_flush, bus4.idex_bubble},
          {12'd0, e.ctl});
      if (e.chk_cnt) begin
        chk(e.name, "stall16", bus16.stall_cycles, e.st);
        chk(e.name, "flush16", bus16.flush_events, e.fl);
        chk(e.name, "stall4", {12'd0, bus4.stall_cycles}, {12'd0, e.st4});
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    //  name          rs     rt     urt   br    mr    rw    dst    pcs   jmp   rst   ctl chk
    vec("rst0",     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, R, 1'b0);
    vec("rst1",     5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b1, R, 1'b1);
    vec("idle",     5'd3,  5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // load-use
    vec("lu",       5'd8,  5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("lu_after", 5'd8,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // load -> branch: RUN->HOLD->RUN, HOLD ignores its inputs
    vec("lb1",      5'd2,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("lb2",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("lb_after", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // ALU -> branch: single stall; $0 never a hazard
    vec("ab",       5'd4,  5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("ab_after", 5'd4,  5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    vec("ab_zero",  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    vec("lu_zero",  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // rt not read -> no hazard
    vec("rt_unused",5'd1,  5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, N, 1'b1);
    vec("rt_used",  5'd1,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, S, 1'b1);
    // flush wins over hazards
    vec("fl_lu",    5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, F, 1'b1);
    vec("jump",     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, F, 1'b1);
    vec("fl_lb",    5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, F, 1'b1);
    vec("fl_lb_nx", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // flush while in HOLD
    vec("hj1",      5'd2,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("hj2",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, F, 1'b1);
    vec("hj_after", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // reset while in HOLD abandons the pending stall
    vec("hr1",      5'd2,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, S, 1'b1);
    vec("hr2",      5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd8,  1'b1, 1'b0, 1'b1, R, 1'b1);
    vec("hr_after", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);
    // saturation on the 4-bit twin
    for (int i = 0; i < 20; i++) begin
      vec("sat",    5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, S, 1'b1);
    end
    vec("sat_end",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, N, 1'b1);

    for (int k = 0; k < 5 && sbq.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Write-side controller for the ID/EX pipeline register.
- Decides each cycle whether the instruction in ID advances, stalls, or is squashed, and drives PC/IF-ID enables plus the bubble (zero-control) select into ID/EX.
- Covers three cases: load-use hazards, branch-in-ID operand hazards (including the two-cycle load→branch case via an FSM), and taken branch/jump flush resolved in EX.
- Also maintains saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_events counters.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- id_is_branch  in  1  ID instruction is a branch compared in ID
- ex_memread  in  1  MemRead of instruction now in EX (ID/EX output)
- ex_regwrite  in  1  RegWrite of instruction now in EX
- ex_dest  in  5  destination register of EX instruction (post RegDst mux)
- ex_pcsrc  in  1  taken branch resolved in EX
- ex_jump  in  1  jump in EX
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads all-zero control fields
- stall_cycles  out  CNT_W  count of stalled cycles
- flush_events  out  CNT_W  count of flush cycles

Behaviour:
- States: RUN, HOLD. Outputs are Mealy: combinational from state and inputs, zero-cycle latency.
- Definitions:
  - match_rs = (ex_dest != 0) && (ex_dest == id_rs).
  - match_rt = id_uses_rt && (ex_dest != 0) && (ex_dest == id_rt).
  - dep = match_rs || match_rt.
  - flush_req = ex_pcsrc || ex_jump.
  - lb_haz = ex_memread && id_is_branch && dep.
  - lu_haz = ex_memread && !id_is_branch && dep.
  - ab_haz = ex_regwrite && !ex_memread && id_is_branch && dep.
- Normal output set: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- STALL output set: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
- FLUSH output set: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
- RUN, priority order:
  1. flush_req → FLUSH; next state RUN.
  2. lb_haz → STALL; next state HOLD.
  3. lu_haz or ab_haz → STALL; next state RUN. The inserted bubble clears the match on the next cycle.
  4. Otherwise → normal; stay RUN.
- HOLD:
  - flush_req → FLUSH; next state RUN (flush always wins).
  - Otherwise → STALL unconditionally; next state RUN. This covers the second load→branch cycle while the load is in MEM; inputs other than flush_req are ignored.
- Register $0 never creates a hazard.
- Counters:
  - stall_cycles increments on every cycle with STALL outputs.
  - flush_events increments on every cycle with FLUSH outputs.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous):
  - Next state RUN; both counters 0.
  - While reset is high, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. Neither counter increments.
- Reset asserted while in HOLD: the pending stall is abandoned and RUN is entered on the next edge.
- Simultaneous flush_req and any hazard: FLUSH only, no stall, only flush_events increments.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants ST_RUN=1'b0, ST_HOLD=1'b1;
  - REG_ZERO=5'd0;
  - opcode constants used by the decoder to derive id_uses_rt and id_is_branch.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
- Load-use: ex_memread=1, ex_dest=8, id_rs=8, id_is_branch=0 → one cycle pc_write=0, idex_bubble=1; next cycle with ex_memread=0 → normal outputs; stall_cycles=1.
- Load→branch: ex_memread=1, ex_dest=9, id_rt=9, id_uses_rt=1, id_is_branch=1 → two consecutive STALL cycles (RUN→HOLD→RUN); stall_cycles=2.
- ALU→branch: ex_regwrite=1, ex_memread=0, ex_dest=4, id_rs=4, id_is_branch=1 → single STALL cycle; same with ex_dest=0 → no stall.
- Flush priority: ex_pcsrc=1 together with lu_haz (ex_dest=8=id_rs) → ifid_flush=1, idex_bubble=1, pc_write=1; flush_events=1, stall_cycles unchanged.
- Flush in HOLD, then reset in HOLD:
  - Enter HOLD via load→branch, assert ex_jump next cycle → FLUSH, state RUN.
  - Repeat entry to HOLD with reset=1 → forced reset outputs, counters 0, RUN afterwards.
- Saturation: CNT_W=4, hold lu_haz for 20 cycles → stall_cycles reaches 15 and stays 15.
